uart_tx: RTL
============

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 CLKS_PER_BIT, 65, clk cycles per bit (legal range 2..65535).
REQ-002 STOP_BITS, 1, number of stop bits (legal values 1 or 2).
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 data  input  8  byte to transmit; sampled only on handshake.
REQ-006 data_valid  input  1  upstream offers data this cycle.
REQ-007 ready  output  1  block accepts data this cycle; handshake = data_valid & ready at rising clk.
REQ-008 tx  output  1  serial line, idle high, registered output.
REQ-009 busy  output  1  high while any frame bit (start/data/parity/stop) is on tx.

Function
REQ-010 Frame SHALL be: start bit 0, data[0]..data[7] (LSB first), optional parity bit (REQ-030), then STOP_BITS stop bits of 1; each bit exactly CLKS_PER_BIT cycles.
REQ-011 States SHALL be IDLE, START, DATA, PARITY, STOP; IDLE->START on load, START->DATA after 1 bit, DATA->PARITY or STOP after bit 7, PARITY->STOP after 1 bit, STOP->START on last stop-bit end if holding register full, otherwise STOP->IDLE.
REQ-012 Block SHALL contain a shifter plus a one-byte holding register; ready = !holding_full.
REQ-013 Handshake in IDLE with holding empty SHALL load the byte directly into the shifter; tx goes 0 on the next rising edge (1-cycle latency).
REQ-014 Handshake while a frame is active SHALL store the byte in the holding register; ready drops the following cycle.
REQ-015 Holding byte SHALL load into the shifter on the last cycle of the final stop bit, so the next start bit follows with zero idle cycles.
REQ-016 Handshake in the same cycle the holding register empties into the shifter SHALL be accepted into the holding register (ready stays 1, no byte lost).
REQ-017 data_valid while ready=0 SHALL be ignored; data not captured, no state change.
REQ-018 Bit counter SHALL be $clog2(CLKS_PER_BIT) wide, count 0..CLKS_PER_BIT-1, and wrap to 0 at each bit boundary.
REQ-019 busy SHALL be 1 in START/DATA/PARITY/STOP and 0 in IDLE; tx SHALL be 1 in IDLE.
REQ-020 data changes after handshake SHALL NOT affect a captured byte.

Reset
REQ-021 On reset=0, SHALL asynchronously force tx=1, busy=0, ready=1, state IDLE, counters 0, holding register empty.
REQ-022 Reset mid-frame SHALL abandon the frame and drop the holding byte; tx goes high immediately without waiting for clk.
REQ-023 After reset deassertion, ready=1 and a handshake on the first rising edge SHALL be accepted.

Configuration
REQ-030 With UART_TX_PARITY_EN defined, SHALL insert one even-parity bit (XOR of data[7:0]) between data[7] and the first stop bit; frame = 10+STOP_BITS bits.
REQ-031 Without UART_TX_PARITY_EN, the PARITY state SHALL NOT exist; DATA->STOP directly; frame = 9+STOP_BITS bits.

Verification
REQ-040 Defaults, no parity: send 8'h41 from IDLE -> tx low 1 cycle after handshake for 65 cycles, then bits 1,0,0,0,0,0,1,0, stop 1; busy high exactly 650 cycles.
REQ-041 Back-to-back: send 8'h41 then 8'h55 during first frame -> ready low until 8'h55 moves to the shifter, second start bit immediately after first stop bit, zero idle gap, 1300 busy cycles.
REQ-042 UART_TX_PARITY_EN defined: send 8'h41 -> parity bit 0 after data[7]; send 8'h07 -> parity bit 1; frame 715 cycles.
REQ-043 STOP_BITS=2: send 8'hFF -> tx high 130 cycles after data[7] before busy falls.
REQ-044 Assert reset during DATA bit 3 with holding full -> tx=1, busy=0, ready=1 at once; no residual frame after release.
REQ-045 Hold data_valid=1 with changing data while ready=0 -> only bytes accepted with ready=1 appear on tx, in order.

Source files
------------

// File: rtl/uart_tx_if.sv
// Byte-stream handshake and serial-line bundle for uart_tx.
interface uart_tx_if;
   logic [7:0] data;
   logic       data_valid;
   logic       ready;
   logic       tx;
   logic       busy;

   modport master (output data, output data_valid, input ready, input tx, input busy);
   modport slave  (input data, input data_valid, output ready, output tx, output busy);
endinterface

// File: rtl/uart_tx.sv
// 8-bit UART transmitter: one-byte holding register in front of the shifter.
// Define UART_TX_PARITY_EN to append an even-parity bit after data[7].
//
// state    | meaning
// S_IDLE   | line high, nothing queued
// S_START  | start bit (0) on tx
// S_DATA   | data bits, LSB first
// S_PARITY | even parity bit (only with UART_TX_PARITY_EN)
// S_STOP   | stop bit(s) (1)
module uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 65,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic     clk,
   input  logic     reset,
   uart_tx_if.slave bus
);

   localparam int unsigned   CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic          stop_q, stop_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    hold_q, hold_d;
   logic          hold_full_q, hold_full_d;
   logic          tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
   logic          parity_q, parity_d;
`endif

   logic       bit_end;
   logic       last_stop;
   logic       frame_end;
   logic       ready;
   logic       accept;
   logic       load_en;
   logic [7:0] load_byte;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         stop_q      <= 1'b0;
         shift_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         tx_q        <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         stop_q      <= stop_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         tx_q        <= tx_d;
`ifdef UART_TX_PARITY_EN
         parity_q    <= parity_d;
`endif
      end
   end

   always_comb begin
      bit_end   = (cnt_q == CNT_LAST);
      last_stop = (STOP_BITS == 1) || stop_q;
      frame_end = (state_q == S_STOP) && bit_end && last_stop;
      // The holding slot frees up in the very cycle it drains into the shifter.
      ready     = !hold_full_q || frame_end;
      accept    = bus.data_valid && ready;

      state_d     = state_q;
      cnt_d       = bit_end ? '0 : cnt_q + CW'(1);
      bit_d       = bit_q;
      stop_d      = stop_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      tx_d        = tx_q;
`ifdef UART_TX_PARITY_EN
      parity_d    = parity_q;
`endif
      load_en     = 1'b0;
      load_byte   = bus.data;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (accept) load_en = 1'b1;
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               bit_d   = 3'd0;
               tx_d    = shift_q[0];
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = S_PARITY;
                  tx_d    = parity_q;
`else
                  state_d = S_STOP;
                  stop_d  = 1'b0;
                  tx_d    = 1'b1;
`endif
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
                  tx_d    = shift_q[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP;
               stop_d  = 1'b0;
               tx_d    = 1'b1;
            end
         end
`endif
         S_STOP: begin
            if (bit_end && !last_stop) stop_d = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
         end
      endcase

      if (frame_end) begin
         if (hold_full_q) begin
            load_en   = 1'b1;
            load_byte = hold_q;
         end else if (accept) begin
            load_en   = 1'b1;
         end else begin
            state_d   = S_IDLE;
            tx_d      = 1'b1;
         end
         hold_full_d = hold_full_q && accept;
         if (hold_full_q && accept) hold_d = bus.data;
      end else if (accept && state_q != S_IDLE) begin
         hold_d      = bus.data;
         hold_full_d = 1'b1;
      end

      if (load_en) begin
         state_d  = S_START;
         shift_d  = load_byte;
         cnt_d    = '0;
         tx_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_d = ^load_byte;
`endif
      end
   end

   assign bus.ready = ready;
   assign bus.tx    = tx_q;
   assign bus.busy  = (state_q != S_IDLE);

endmodule
